// File: rtl/pwm_fade_controller_pkg.sv
// Shared definitions for the PWM duty fade controller.
//   fade_state_t    : controller state encoding (IDLE=0, UP=1, DOWN=2)
//   PRESCALE_W_DEF  : default prescaler width
//   eff_step()      : effective step size (a programmed step of 0 behaves as 1)
package pwm_fade_controller_pkg;

   localparam int PRESCALE_W_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_UP   = 2'd1,
      ST_DOWN = 2'd2
   } fade_state_t;

   function automatic logic [8:0] eff_step(input logic [7:0] step);
      return (step == 8'd0) ? 9'd1 : {1'b0, step};
   endfunction

endpackage

// File: rtl/pwm_fade_controller_tick_gen.sv
// fade_tick_gen: prescaler plus rate divider producing the fade step strobe.
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   clr        : synchronous clear of both counters (held while idle / on retarget)
//   rate_div   : step period = (rate_div+1) * 2**PRESCALE_W cycles, read live
//   step_tick  : one-cycle strobe on the prescaler wrap that ends a step period
module fade_tick_gen
   import pwm_fade_controller_pkg::*;
#(
   parameter int PRESCALE_W = PRESCALE_W_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic [7:0] rate_div,
   output logic       step_tick
);

   logic [PRESCALE_W-1:0] pre_cnt;
   logic [7:0]            div_cnt;
   logic                  pre_wrap;

   assign pre_wrap = &pre_cnt;

   // >= rather than == so that lowering rate_div below the running divider
   // count ends the period at once instead of waiting for an 8-bit wrap.
   assign step_tick = pre_wrap && (div_cnt >= rate_div);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_cnt <= '0;
         div_cnt <= '0;
      end else if (clr) begin
         pre_cnt <= '0;
         div_cnt <= '0;
      end else begin
         pre_cnt <= pre_cnt + 1'b1;
         if (pre_wrap) begin
            div_cnt <= step_tick ? 8'd0 : div_cnt + 8'd1;
         end
      end
   end

endmodule

// File: rtl/pwm_fade_controller.sv
// pwm_fade_controller: ramps the live PWM duty toward an SPI-written target.
//   clk          : system clock
//   rst_n        : asynchronous active-low reset
//   target_duty  : requested duty, captured on target_wr
//   target_wr    : one-cycle write strobe for target_duty
//   fade_en      : 1 = ramp in steps, 0 = apply target immediately
//   rate_div     : step period divider, (rate_div+1) * 2**PRESCALE_W cycles
//   step_size    : duty change per step (0 behaves as 1)
//   duty_out     : live duty to the PWM peripheral
//   busy         : high while ramping (UP or DOWN)
//   done         : one-cycle pulse when duty_out reaches the target
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | duty_out stable, tick counters held cleared
// UP    | duty_out below target_reg, increments on each step_tick
// DOWN  | duty_out above target_reg, decrements on each step_tick
module pwm_fade_controller
   import pwm_fade_controller_pkg::*;
#(
   parameter int PRESCALE_W = PRESCALE_W_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] target_duty,
   input  logic       target_wr,
   input  logic       fade_en,
   input  logic [7:0] rate_div,
   input  logic [7:0] step_size,
   output logic [7:0] duty_out,
   output logic       busy,
   output logic       done
);

   fade_state_t state;
   logic [7:0]  target_reg;
   logic        step_tick;
   logic        tick_clr;
   logic [8:0]  step_eff;
   logic [8:0]  gap;

   // A write restarts the step period, so the write always wins over a
   // coincident step_tick.
   assign tick_clr = target_wr || (state == ST_IDLE);

   fade_tick_gen #(
      .PRESCALE_W (PRESCALE_W)
   ) u_tick_gen (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (tick_clr),
      .rate_div  (rate_div),
      .step_tick (step_tick)
   );

   // Remaining distance in 9 bits; always non-negative in the state that uses it.
   always_comb begin
      step_eff = eff_step(step_size);
      gap      = 9'd0;
      if (state == ST_DOWN) begin
         gap = {1'b0, duty_out} - {1'b0, target_reg};
      end else begin
         gap = {1'b0, target_reg} - {1'b0, duty_out};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         duty_out   <= 8'd0;
         target_reg <= 8'd0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         if (target_wr) begin
            target_reg <= target_duty;
            if (!fade_en || (target_duty == duty_out)) begin
               duty_out <= target_duty;
               done     <= 1'b1;
               state    <= ST_IDLE;
               busy     <= 1'b0;
            end else if (target_duty > duty_out) begin
               state <= ST_UP;
               busy  <= 1'b1;
            end else begin
               state <= ST_DOWN;
               busy  <= 1'b1;
            end
         end else if ((state != ST_IDLE) && !fade_en) begin
            duty_out <= target_reg;
            done     <= 1'b1;
            state    <= ST_IDLE;
            busy     <= 1'b0;
         end else if (step_tick && (state != ST_IDLE)) begin
            if (gap <= step_eff) begin
               duty_out <= target_reg;
               done     <= 1'b1;
               state    <= ST_IDLE;
               busy     <= 1'b0;
            end else if (state == ST_UP) begin
               duty_out <= duty_out + step_eff[7:0];
            end else begin
               duty_out <= duty_out - step_eff[7:0];
            end
         end
      end
   end

endmodule

// File: tb/tb_pwm_fade_controller.sv
// Directed bench for pwm_fade_controller with PRESCALE_W=2 (step period
// (rate_div+1)*4 cycles). Inputs change and outputs are sampled on negedge.
module tb_pwm_fade_controller;

   logic       clk;
   logic       rst_n;
   logic [7:0] target_duty;
   logic       target_wr;
   logic       fade_en;
   logic [7:0] rate_div;
   logic [7:0] step_size;
   logic [7:0] duty_out;
   logic       busy;
   logic       done;

   int n_cmp = 0;
   int n_err = 0;
   int done_seen = 0;
   int done_base;

   pwm_fade_controller #(
      .PRESCALE_W (2)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .target_duty (target_duty),
      .target_wr   (target_wr),
      .fade_en     (fade_en),
      .rate_div    (rate_div),
      .step_size   (step_size),
      .duty_out    (duty_out),
      .busy        (busy),
      .done        (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Advance n negedges, counting done pulses seen along the way.
   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (done === 1'b1) done_seen++;
      end
   endtask

   task automatic pulse_wr(input logic [7:0] val);
      target_duty = val;
      target_wr   = 1'b1;
      cyc(1);
      target_wr   = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      cyc(2);
      pulse_wr(8'h80);
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if ({duty_out, busy, done} !== {8'h00, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_hold: duty=%0h busy=%0b done=%0b, want 0/0/0", duty_out, busy, done);
         end
         cyc(1);
      end
      rst_n = 1'b1;
      cyc(6);
      n_cmp++;
      if ({duty_out, busy} !== {8'h00, 1'b0}) begin
         n_err++;
         $display("FAIL reset_release: duty=%0h busy=%0b, want 0/0", duty_out, busy);
      end
      n_cmp++;
      if (done_seen !== 0) begin
         n_err++;
         $display("FAIL reset_no_done: done pulses=%0d, want 0", done_seen);
      end
   endtask

   task automatic test_fade_up();
      logic [7:0] exp;
      done_base = done_seen;
      fade_en = 1'b1; rate_div = 8'd0; step_size = 8'h10;
      pulse_wr(8'h40);
      n_cmp++;
      if ({busy, duty_out} !== {1'b1, 8'h00}) begin
         n_err++;
         $display("FAIL up_start: busy=%0b duty=%0h, want 1/00", busy, duty_out);
      end
      for (int s = 1; s <= 4; s++) begin
         cyc(3);
         exp = 8'((s - 1) * 16);
         n_cmp++;
         if (duty_out !== exp) begin
            n_err++;
            $display("FAIL up_hold%0d: duty=%0h, want %0h", s, duty_out, exp);
         end
         cyc(1);
         exp = 8'(s * 16);
         n_cmp++;
         if (duty_out !== exp) begin
            n_err++;
            $display("FAIL up_step%0d: duty=%0h, want %0h", s, duty_out, exp);
         end
      end
      n_cmp++;
      if ({done, busy} !== {1'b1, 1'b0}) begin
         n_err++;
         $display("FAIL up_done: done=%0b busy=%0b, want 1/0", done, busy);
      end
      cyc(8);
      n_cmp++;
      if (done_seen - done_base !== 1) begin
         n_err++;
         $display("FAIL up_done_count: pulses=%0d, want 1", done_seen - done_base);
      end
   endtask

   task automatic test_fade_down();
      done_base = done_seen;
      step_size = 8'h30; rate_div = 8'd1;
      pulse_wr(8'h05);
      n_cmp++;
      if (busy !== 1'b1) begin
         n_err++;
         $display("FAIL down_busy: busy=%0b, want 1", busy);
      end
      cyc(7);
      n_cmp++;
      if (duty_out !== 8'h40) begin
         n_err++;
         $display("FAIL down_hold: duty=%0h, want 40", duty_out);
      end
      cyc(1);
      n_cmp++;
      if (duty_out !== 8'h10) begin
         n_err++;
         $display("FAIL down_step1: duty=%0h, want 10", duty_out);
      end
      cyc(8);
      n_cmp++;
      if ({duty_out, done, busy} !== {8'h05, 1'b1, 1'b0}) begin
         n_err++;
         $display("FAIL down_final: duty=%0h done=%0b busy=%0b, want 05/1/0", duty_out, done, busy);
      end
      cyc(10);
      n_cmp++;
      if ({duty_out, done_seen - done_base} !== {8'h05, 32'd1}) begin
         n_err++;
         $display("FAIL down_settle: duty=%0h pulses=%0d, want 05/1", duty_out, done_seen - done_base);
      end
   endtask

   task automatic test_retarget();
      logic [7:0] exp;
      fade_en = 1'b0;
      pulse_wr(8'h00);
      fade_en = 1'b1; step_size = 8'h08; rate_div = 8'd0;
      done_base = done_seen;
      pulse_wr(8'hFF);
      cyc(32);
      n_cmp++;
      if ({duty_out, busy} !== {8'h40, 1'b1}) begin
         n_err++;
         $display("FAIL retgt_mid: duty=%0h busy=%0b, want 40/1", duty_out, busy);
      end
      pulse_wr(8'h20);
      n_cmp++;
      if ({duty_out, busy, done} !== {8'h40, 1'b1, 1'b0}) begin
         n_err++;
         $display("FAIL retgt_hold: duty=%0h busy=%0b done=%0b, want 40/1/0", duty_out, busy, done);
      end
      for (int s = 1; s <= 4; s++) begin
         cyc(4);
         exp = 8'(8'h40 - s * 8);
         n_cmp++;
         if (duty_out !== exp) begin
            n_err++;
            $display("FAIL retgt_step%0d: duty=%0h, want %0h", s, duty_out, exp);
         end
      end
      cyc(8);
      n_cmp++;
      if ({duty_out, busy, done_seen - done_base} !== {8'h20, 1'b0, 32'd1}) begin
         n_err++;
         $display("FAIL retgt_end: duty=%0h busy=%0b pulses=%0d, want 20/0/1", duty_out, busy, done_seen - done_base);
      end
   endtask

   task automatic test_no_fade();
      logic busy_hi;
      fade_en = 1'b0;
      pulse_wr(8'hC3);
      n_cmp++;
      if ({duty_out, done, busy} !== {8'hC3, 1'b1, 1'b0}) begin
         n_err++;
         $display("FAIL nofade: duty=%0h done=%0b busy=%0b, want C3/1/0", duty_out, done, busy);
      end
      busy_hi = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cyc(1);
         if (busy === 1'b1) busy_hi = 1'b1;
      end
      n_cmp++;
      if ({busy_hi, done} !== {1'b0, 1'b0}) begin
         n_err++;
         $display("FAIL nofade_quiet: busy_seen=%0b done=%0b, want 0/0", busy_hi, done);
      end
      fade_en = 1'b1; step_size = 8'h10; rate_div = 8'd0;
      pulse_wr(8'h03);
      cyc(4);
      n_cmp++;
      if ({duty_out, busy} !== {8'hB3, 1'b1}) begin
         n_err++;
         $display("FAIL drop_pre: duty=%0h busy=%0b, want B3/1", duty_out, busy);
      end
      cyc(1);
      fade_en = 1'b0;
      cyc(1);
      n_cmp++;
      if ({duty_out, done, busy} !== {8'h03, 1'b1, 1'b0}) begin
         n_err++;
         $display("FAIL drop_jump: duty=%0h done=%0b busy=%0b, want 03/1/0", duty_out, done, busy);
      end
   endtask

   task automatic test_step_zero();
      fade_en = 1'b1; step_size = 8'h00; rate_div = 8'd0;
      pulse_wr(8'h05);
      cyc(4);
      n_cmp++;
      if (duty_out !== 8'h04) begin
         n_err++;
         $display("FAIL step0_first: duty=%0h, want 04", duty_out);
      end
      cyc(4);
      n_cmp++;
      if ({duty_out, done, busy} !== {8'h05, 1'b1, 1'b0}) begin
         n_err++;
         $display("FAIL step0_end: duty=%0h done=%0b busy=%0b, want 05/1/0", duty_out, done, busy);
      end
   endtask

   task automatic test_async_reset();
      fade_en = 1'b0;
      pulse_wr(8'h00);
      fade_en = 1'b1; step_size = 8'h10; rate_div = 8'd0;
      pulse_wr(8'h80);
      cyc(12);
      n_cmp++;
      if ({duty_out, busy} !== {8'h30, 1'b1}) begin
         n_err++;
         $display("FAIL arst_pre: duty=%0h busy=%0b, want 30/1", duty_out, busy);
      end
      done_base = done_seen;
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({duty_out, busy, done} !== {8'h00, 1'b0, 1'b0}) begin
         n_err++;
         $display("FAIL arst_now: duty=%0h busy=%0b done=%0b, want 00/0/0", duty_out, busy, done);
      end
      cyc(2);
      rst_n = 1'b1;
      cyc(20);
      n_cmp++;
      if ({duty_out, busy, done_seen - done_base} !== {8'h00, 1'b0, 32'd0}) begin
         n_err++;
         $display("FAIL arst_after: duty=%0h busy=%0b pulses=%0d, want 00/0/0", duty_out, busy, done_seen - done_base);
      end
      pulse_wr(8'h00);
      n_cmp++;
      if ({duty_out, done, busy} !== {8'h00, 1'b1, 1'b0}) begin
         n_err++;
         $display("FAIL equal_wr: duty=%0h done=%0b busy=%0b, want 00/1/0", duty_out, done, busy);
      end
      cyc(1);
      n_cmp++;
      if ({done, busy} !== {1'b0, 1'b0}) begin
         n_err++;
         $display("FAIL equal_wr_after: done=%0b busy=%0b, want 0/0", done, busy);
      end
   endtask

   initial begin
      rst_n       = 1'b0;
      target_duty = 8'h00;
      target_wr   = 1'b0;
      fade_en     = 1'b0;
      rate_div    = 8'd0;
      step_size   = 8'd0;
      test_reset();
      test_fade_up();
      test_fade_down();
      test_retarget();
      test_no_fade();
      test_step_zero();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
